// File: rtl/mem_loader_pkg.sv
// Shared types and helpers for the boot-time TCM loader.
//   state_e      : loader FSM states
//   wr_word_t    : one packed TCM write payload (data + byte enables)
//   be_from_count: byte-enable mask for a word holding n valid low bytes
package mem_loader_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned BE_W       = WORD_BYTES;
    localparam int unsigned LANE_W     = 2;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [WORD_W-1:0] data;
    } wr_word_t;

    // n in 1..4 -> low n bits set (4 -> 4'hF)
    function automatic logic [BE_W-1:0] be_from_count(input logic [CNT_W-1:0] n);
        return BE_W'((5'd1 << n) - 5'd1);
    endfunction

endpackage

// File: rtl/mem_loader_packer.sv
// Byte-lane packer: collects stream bytes little-endian into a 32-bit word.
//   clk, rst_n  : clock, async active-low reset
//   clr_i       : drop any partially packed word
//   push_i      : a byte is accepted this cycle
//   flush_i     : the pushed byte is the last of the image (emit partial word)
//   byte_i      : byte being pushed
//   word_c_o    : word including the pushed byte, unused lanes zero, with BE
//   full_c_o    : word_c_o is to be written this cycle (4th lane or flush)
module mem_loader_packer
    import mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              flush_i,
    input  logic [BYTE_W-1:0] byte_i,
    output wr_word_t          word_c_o,
    output logic              full_c_o
);

    logic [WORD_W-1:0] data_q;
    logic [LANE_W-1:0] lane_q;

    // Merge the incoming byte into its lane; empty lanes stay zero
    always_comb begin
        word_c_o.data                          = data_q;
        word_c_o.data[{lane_q, 3'b000} +: BYTE_W] = byte_i;
        word_c_o.be                            = be_from_count(CNT_W'(lane_q) + CNT_W'(1));
        full_c_o = push_i && ((CNT_W'(lane_q) + CNT_W'(1) == CNT_W'(WORD_BYTES)) || flush_i);
    end

    // Lane register; cleared after every emitted word so partial words zero-pad
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            lane_q <= '0;
        end else if (clr_i || full_c_o) begin
            data_q <= '0;
            lane_q <= '0;
        end else if (push_i) begin
            data_q <= word_c_o.data;
            lane_q <= lane_q + LANE_W'(1);
        end
    end

endmodule

// File: rtl/mem_boot_loader.sv
// Boot loader: receives a 4-byte LE length header then image bytes, packs
// them into 32-bit LE words written sequentially from BASE_ADDR, and holds
// the core in reset until the image is complete.
// Optional: MEM_LOADER_CHECKSUM_EN adds a trailing 4-byte LE checksum that
// must equal the modulo-2^32 sum of all written words.
//   clk, rst_n            : clock, async active-low reset
//   start_i               : begin a load (IDLE/DONE/ERR only)
//   byte_data_i/valid_i   : byte stream in
//   byte_ready_o          : byte accepted when valid & ready
//   mem_we_o/addr_o/wdata_o/be_o : TCM word write port
//   busy_o, done_o, err_o : status
//   core_rst_n_o          : core reset, released only when done
module mem_boot_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_BYTES = 16384
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] byte_data_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              core_rst_n_o
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] field_q, field_d;    // length header, later the checksum
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;      // bytes of field_q received
    logic [31:0]       cnt_q, cnt_d;        // image bytes received
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic              fin_q, fin_d;        // final word being written this cycle

    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              crst_n_q, crst_n_d;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d;
`endif

    logic     accept_c;
    logic     last_c;
    logic     pk_clr, pk_push, pk_flush, pk_full;
    wr_word_t pk_word;

    assign accept_c = byte_valid_i && ready_q;
    assign last_c   = (cnt_q + 32'd1) == field_q;

    mem_loader_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (pk_clr),
        .push_i   (pk_push),
        .flush_i  (pk_flush),
        .byte_i   (byte_data_i),
        .word_c_o (pk_word),
        .full_c_o (pk_full)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            field_q  <= '0;
            fcnt_q   <= '0;
            cnt_q    <= '0;
            widx_q   <= '0;
            fin_q    <= 1'b0;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            crst_n_q <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            field_q  <= field_d;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
            widx_q   <= widx_d;
            fin_q    <= fin_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            crst_n_q <= crst_n_d;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        field_d  = field_q;
        fcnt_d   = fcnt_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        fin_d    = fin_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        pk_clr   = 1'b0;
        pk_push  = 1'b0;
        pk_flush = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d = ST_HDR;
                    field_d = '0;
                    fcnt_d  = '0;
                    cnt_d   = '0;
                    widx_d  = '0;
                    fin_d   = 1'b0;
                    pk_clr  = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_HDR: begin
                // One evaluation cycle after the 4th header byte
                if (fcnt_q == CNT_W'(WORD_BYTES)) begin
                    if (field_q == '0)
                        state_d = ST_DONE;
                    else if (field_q > 32'(MAX_BYTES))
                        state_d = ST_ERR;
                    else
                        state_d = ST_LOAD;
                end else if (accept_c) begin
                    field_d[{fcnt_q[LANE_W-1:0], 3'b000} +: BYTE_W] = byte_data_i;
                    fcnt_d = fcnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (fin_q) begin
                    fin_d = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
                    field_d = '0;
                    fcnt_d  = '0;
`else
                    state_d = ST_DONE;
`endif
                end else if (accept_c) begin
                    pk_push  = 1'b1;
                    pk_flush = last_c;
                    cnt_d    = cnt_q + 32'd1;
                    fin_d    = last_c;
                    if (pk_full) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'(BASE_ADDR) + widx_q;
                        wdata_d = pk_word.data;
                        be_d    = pk_word.be;
                        widx_d  = widx_q + ADDR_W'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + pk_word.data;
`endif
                    end
                end
            end
            ST_CSUM: begin
`ifdef MEM_LOADER_CHECKSUM_EN
                if (fcnt_q == CNT_W'(WORD_BYTES)) begin
                    state_d = (field_q == sum_q) ? ST_DONE : ST_ERR;
                end else if (accept_c) begin
                    field_d[{fcnt_q[LANE_W-1:0], 3'b000} +: BYTE_W] = byte_data_i;
                    fcnt_d = fcnt_q + CNT_W'(1);
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready is dropped while a field is complete and in the write cycle
        ready_d = 1'b0;
        unique case (state_d)
            ST_HDR, ST_CSUM: ready_d = (fcnt_d != CNT_W'(WORD_BYTES));
            ST_LOAD:         ready_d = !we_d && !fin_d;
            default:         ready_d = 1'b0;
        endcase

        busy_d   = (state_d == ST_HDR) || (state_d == ST_LOAD) || (state_d == ST_CSUM);
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_ERR);
        crst_n_d = (state_d == ST_DONE);
    end

    assign byte_ready_o = ready_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_be_o     = be_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign core_rst_n_o = crst_n_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
module tb_mem_boot_loader;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned MAX_BYTES = 16384;

    logic              clk;
    logic              rst_n;
    logic              start_i;
    logic [7:0]        byte_data_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              core_rst_n_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_addr [0:63];
    logic [31:0] cap_data [0:63];
    logic [3:0]  cap_be   [0:63];
    int          wr_cnt  = 0;
    int          overlap = 0;
    int          base;

    mem_boot_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (0),
        .MAX_BYTES (MAX_BYTES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .byte_data_i  (byte_data_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .core_rst_n_o (core_rst_n_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write capture and ready/write overlap monitor
    always @(negedge clk) begin
        if (mem_we_o === 1'b1 && wr_cnt < 64) begin
            cap_addr[wr_cnt] <= 32'(mem_addr_o);
            cap_data[wr_cnt] <= mem_wdata_o;
            cap_be[wr_cnt]   <= mem_be_o;
            wr_cnt           <= wr_cnt + 1;
        end
        if (rst_n === 1'b1 && mem_we_o === 1'b1 && byte_ready_o === 1'b1)
            overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        while (byte_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("byte_ready_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[7:0]);
            t = t >> 8;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        chk({tag, "_we"},    32'(mem_we_o),     32'd0);
        chk({tag, "_addr"},  32'(mem_addr_o),   32'd0);
        chk({tag, "_wdata"}, mem_wdata_o,       32'd0);
        chk({tag, "_be"},    32'(mem_be_o),     32'd0);
        chk({tag, "_busy"},  32'(busy_o),       32'd0);
        chk({tag, "_done"},  32'(done_o),       32'd0);
        chk({tag, "_err"},   32'(err_o),        32'd0);
        chk({tag, "_crst"},  32'(core_rst_n_o), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start_i      = 1'b0;
        byte_data_i  = 8'h00;
        byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // len=8, bytes 01..08
        pulse_start();
        chk("hdr_busy", 32'(busy_o), 32'd1);
        base = wr_cnt;
        send_word(32'd8);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
`ifdef MEM_LOADER_CHECKSUM_EN
        send_word(32'h0C0A0806);
`endif
        settle();
        chk("l8_wcount", 32'(wr_cnt - base), 32'd2);
        chk("l8_addr0", cap_addr[base],   32'd0);
        chk("l8_data0", cap_data[base],   32'h04030201);
        chk("l8_be0",   32'(cap_be[base]), 32'hF);
        chk("l8_addr1", cap_addr[base+1], 32'd1);
        chk("l8_data1", cap_data[base+1], 32'h08070605);
        chk("l8_be1",   32'(cap_be[base+1]), 32'hF);
        chk("l8_done",  32'(done_o),       32'd1);
        chk("l8_crst",  32'(core_rst_n_o), 32'd1);
        chk("l8_err",   32'(err_o),        32'd0);
        chk("l8_busy",  32'(busy_o),       32'd0);

        // len=5, AA BB CC DD EE; restart from DONE clears flags
        pulse_start();
        chk("restart_done", 32'(done_o),       32'd0);
        chk("restart_crst", 32'(core_rst_n_o), 32'd0);
        base = wr_cnt;
        send_word(32'd5);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
`ifndef MEM_LOADER_CHECKSUM_EN
        @(negedge clk);
        chk("l5_final_we",    32'(mem_we_o), 32'd1);
        chk("l5_done_early",  32'(done_o),   32'd0);
        @(negedge clk);
        chk("l5_done_latency", 32'(done_o),  32'd1);
        chk("l5_we_pulse",    32'(mem_we_o), 32'd0);
`else
        send_word(32'hDDCCBC98);
`endif
        settle();
        chk("l5_wcount", 32'(wr_cnt - base), 32'd2);
        chk("l5_addr0", cap_addr[base],   32'd0);
        chk("l5_data0", cap_data[base],   32'hDDCCBBAA);
        chk("l5_be0",   32'(cap_be[base]), 32'hF);
        chk("l5_addr1", cap_addr[base+1], 32'd1);
        chk("l5_data1", cap_data[base+1], 32'h000000EE);
        chk("l5_be1",   32'(cap_be[base+1]), 32'h1);
        chk("l5_done",  32'(done_o), 32'd1);

        // len=0: done two cycles after 4th header byte, no writes
        pulse_start();
        base = wr_cnt;
        send_word(32'd0);
        @(negedge clk);
        chk("l0_done_early", 32'(done_o), 32'd0);
        @(negedge clk);
        chk("l0_done", 32'(done_o), 32'd1);
        settle();
        chk("l0_wcount", 32'(wr_cnt - base), 32'd0);
        chk("l0_crst",   32'(core_rst_n_o),  32'd1);

        // len=MAX_BYTES+1 -> error
        pulse_start();
        base = wr_cnt;
        send_word(32'(MAX_BYTES + 1));
        settle();
        chk("big_err",    32'(err_o),          32'd1);
        chk("big_done",   32'(done_o),         32'd0);
        chk("big_crst",   32'(core_rst_n_o),   32'd0);
        chk("big_ready",  32'(byte_ready_o),   32'd0);
        chk("big_wcount", 32'(wr_cnt - base),  32'd0);

        // Reset mid-load after 3 image bytes
        pulse_start();
        chk("err_cleared", 32'(err_o), 32'd0);
        base = wr_cnt;
        send_word(32'd8);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        byte_valid_i = 1'b1;
        byte_data_i  = 8'h55;
        repeat (6) @(negedge clk);
        byte_valid_i = 1'b0;
        #1;
        chk("midrst_wcount", 32'(wr_cnt - base), 32'd0);
        chk("midrst_ready",  32'(byte_ready_o),  32'd0);

        // Clean reload after reset
        pulse_start();
        base = wr_cnt;
        send_word(32'd8);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i));
`ifdef MEM_LOADER_CHECKSUM_EN
        send_word(32'h2C2A2826);
`endif
        settle();
        chk("rl_wcount", 32'(wr_cnt - base), 32'd2);
        chk("rl_data0",  cap_data[base],   32'h14131211);
        chk("rl_data1",  cap_data[base+1], 32'h18171615);
        chk("rl_addr1",  cap_addr[base+1], 32'd1);
        chk("rl_done",   32'(done_o),       32'd1);
        chk("rl_crst",   32'(core_rst_n_o), 32'd1);

`ifdef MEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        pulse_start();
        send_word(32'd4);
        send_word(32'h00000001);
        send_word(32'h00000001);
        settle();
        chk("csum_ok_done", 32'(done_o), 32'd1);
        chk("csum_ok_err",  32'(err_o),  32'd0);
        pulse_start();
        send_word(32'd4);
        send_word(32'h00000001);
        send_word(32'h00000002);
        settle();
        chk("csum_bad_err",  32'(err_o),        32'd1);
        chk("csum_bad_done", 32'(done_o),       32'd0);
        chk("csum_bad_crst", 32'(core_rst_n_o), 32'd0);
`endif

        chk("ready_we_overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
